// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder
//   This block holds DIGITS packed BCD digits and shows them one at a time
//   on a multiplexed display. It scans the digits in turn, and each digit
//   stays selected for SCAN_DIV clock cycles.
//
//   New values are double-buffered. A load goes into a shadow register. The
//   active register takes the shadow only at a frame boundary, so a frame
//   never shows digits from two different values.
//
//   Optional build macro: BCD_SCAN_LEADING_ZERO_BLANK_EN
//     When defined, leading zero digits above digit 0 are shown blank.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         1 = scan; 0 = blank the outputs and park the scan at digit 0
//   load       strobe that captures bcd_in
//   bcd_in     packed BCD input; digit k is bcd_in[4k+3:4k]
//   dec_out    one-hot decimal value of the shown digit (bit n = value n)
//   dig_sel    one-hot select of the shown digit
//   dig_idx    binary index of the shown digit
//   invalid    the shown digit holds a code from 10 to 15
//   frame_done one-cycle pulse after the last digit's slot ends
module bcd_scan_decoder #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 4,
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [9:0]            dec_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [IW-1:0]         dig_idx,
   output logic                  invalid,
   output logic                  frame_done
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {BLANK, SCAN} state_t;

   state_t                state_q, state_d;
   logic [DW-1:0]         div_q, div_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*DIGITS-1:0]   active_q, active_d;
   logic                  pending_q, pending_d;
   logic [9:0]            dec_q, dec_d;
   logic [DIGITS-1:0]     sel_q, sel_d;
   logic [IW-1:0]         didx_q, didx_d;
   logic                  inv_q, inv_d;
   logic                  fdone_q, fdone_d;

   logic [3:0]            cur;
   logic                  lz_blank;
   logic [9:0]            dec_shown;
   logic                  last_slot, last_dig, xfer;

   // This is the digit at idx_q, taken from active_q before the edge.
   always_comb begin
      cur = 4'(active_q >> (4 * int'(idx_q)));
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
      // A digit is blanked when it and every digit above it are zero.
      // An invalid code is nonzero, so it already stops blanking below it.
      lz_blank = (idx_q != '0) && ((active_q >> (4 * int'(idx_q))) == '0);
`else
      lz_blank = 1'b0;
`endif
      dec_shown = (cur <= 4'd9 && !lz_blank) ? (10'd1 << cur) : 10'd0;
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      dec_d     = '0;
      sel_d     = '0;
      didx_d    = '0;
      inv_d     = 1'b0;
      fdone_d   = 1'b0;
      xfer      = 1'b0;
      last_slot = (div_q == DW'(SCAN_DIV - 1));
      last_dig  = (idx_q == IW'(DIGITS - 1));

      case (state_q)
         BLANK: begin
            div_d = '0;
            idx_d = '0;
            // Entering SCAN acts as a frame boundary for the double buffer.
            if (en) begin
               state_d = SCAN;
               xfer    = 1'b1;
            end
         end
         SCAN: begin
            if (!en) begin
               state_d = BLANK;
               div_d   = '0;
               idx_d   = '0;
            end else begin
               dec_d  = dec_shown;
               sel_d  = DIGITS'(1) << idx_q;
               didx_d = idx_q;
               inv_d  = (cur > 4'd9);
               if (last_slot) begin
                  div_d = '0;
                  if (last_dig) begin
                     idx_d   = '0;
                     xfer    = 1'b1;
                     fdone_d = 1'b1;
                  end else begin
                     idx_d = IW'(idx_q + 1'b1);
                  end
               end else begin
                  div_d = DW'(div_q + 1'b1);
               end
            end
         end
         default: state_d = BLANK;
      endcase

      // A load on the boundary edge goes straight to active. Otherwise the
      // shadow value moves to active at the boundary if one is pending.
      if (xfer && load) begin
         active_d  = bcd_in;
         shadow_d  = bcd_in;
         pending_d = 1'b0;
      end else begin
         if (xfer && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
         if (load) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= BLANK;
         div_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         dec_q     <= '0;
         sel_q     <= '0;
         didx_q    <= '0;
         inv_q     <= 1'b0;
         fdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         dec_q     <= dec_d;
         sel_q     <= sel_d;
         didx_q    <= didx_d;
         inv_q     <= inv_d;
         fdone_q   <= fdone_d;
      end
   end

   assign dec_out    = dec_q;
   assign dig_sel    = sel_q;
   assign dig_idx    = didx_q;
   assign invalid    = inv_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Scoreboard bench for bcd_scan_decoder with DIGITS=4 and SCAN_DIV=2.
// The reference model tracks the scan as a count of cycles since scanning
// began, and keeps the digits as plain 16-bit words.
module tb_bcd_scan_decoder;
   localparam int DIG = 4;
   localparam int SD  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, load;
   logic [15:0] bcd_in;
   logic [9:0]  dec_out;
   logic [3:0]  dig_sel;
   logic [1:0]  dig_idx;
   logic        invalid, frame_done;

   bcd_scan_decoder #(.DIGITS(DIG), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
      .dec_out(dec_out), .dig_sel(dig_sel), .dig_idx(dig_idx),
      .invalid(invalid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] dec;
      logic [3:0] sel;
      logic [1:0] idx;
      logic       inv;
      logic       fd;
   } out_t;

   out_t q[$];
   int total = 0;
   int bad   = 0;

   // Model state
   bit          m_scan;
   int          m_t;        // edges spent in SCAN since it was entered
   logic [15:0] m_shadow, m_active;
   bit          m_pending;

   function automatic void model_reset();
      m_scan = 0; m_t = 0; m_shadow = 0; m_active = 0; m_pending = 0;
   endfunction

   function automatic int cur_slot();
      return (m_t / SD) % DIG;
   endfunction

   function automatic bit next_is_boundary();
      return m_scan && ((m_t + 1) % (SD * DIG) == 0);
   endfunction

   function automatic out_t model_edge(input bit e, input bit l, input logic [15:0] b);
      out_t o;
      bit boundary;
      int slot;
      logic [3:0] d;
      bit blank;
      o = '0;
      boundary = 0;
      if (m_scan && e) begin
         slot  = cur_slot();
         d     = 4'(m_active >> (4 * slot));
         blank = 0;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
         if (slot > 0 && (m_active >> (4 * slot)) == 16'd0) blank = 1;
`endif
         o.dec = (d < 10 && !blank) ? 10'(1 << d) : 10'd0;
         o.sel = 4'(1 << slot);
         o.idx = 2'(slot);
         o.inv = (d >= 10);
         o.fd  = next_is_boundary();
         boundary = o.fd;
      end else if (!m_scan && e) begin
         boundary = 1;
      end
      if (boundary && l) begin
         m_active = b; m_shadow = b; m_pending = 0;
      end else begin
         if (boundary && m_pending) begin
            m_active = m_shadow; m_pending = 0;
         end
         if (l) begin
            m_shadow = b; m_pending = 1;
         end
      end
      m_t    = (m_scan && e) ? m_t + 1 : 0;
      m_scan = e;
      return o;
   endfunction

   task automatic step(input bit e, input bit l, input logic [15:0] b);
      out_t exp;
      en = e; load = l; bcd_in = b;
      exp = model_edge(e, l, b);
      @(posedge clk);
      q.push_back(exp);
      #1;
   endtask

   // Apply reset between clock edges, after the pending expectation has been
   // checked.
   task automatic mid_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // The monitor checks outputs at the falling edge. It also checks that
   // outputs clear right away when reset is asserted.
   initial begin
      out_t exp, act;
      #2;
      total++;
      if ({dec_out, dig_sel, dig_idx, invalid, frame_done} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h want=0", {dec_out, dig_sel, dig_idx, invalid, frame_done});
      end
      forever begin
         @(negedge clk or posedge rst);
         act = {dec_out, dig_sel, dig_idx, invalid, frame_done};
         if (rst) begin
            #1;
            act = {dec_out, dig_sel, dig_idx, invalid, frame_done};
            total++;
            if (act !== '0) begin
               bad++;
               $display("FAIL async_reset t=%0t got=%h want=0", $time, act);
            end
            q.delete();
         end else if (q.size() > 0) begin
            exp = q.pop_front();
            total++;
            if (act !== exp) begin
               bad++;
               $display("FAIL scan_out t=%0t got dec=%b sel=%b idx=%0d inv=%b fd=%b want dec=%b sel=%b idx=%0d inv=%b fd=%b",
                        $time, act.dec, act.sel, act.idx, act.inv, act.fd,
                        exp.dec, exp.sel, exp.idx, exp.inv, exp.fd);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 0; load = 0; bcd_in = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      // 1: basic scan of 1234
      step(0, 1, 16'h1234);
      repeat (20) step(1, 0, 0);
      // 2: invalid digit in slot 1
      step(1, 1, 16'h12F4);
      repeat (16) step(1, 0, 0);
      // 3: mid-frame load must not tear
      step(1, 1, 16'h1234);
      repeat (10) step(1, 0, 0);
      for (int i = 0; i < 16 && cur_slot() != 1; i++) step(1, 0, 0);
      step(1, 1, 16'h9876);
      repeat (16) step(1, 0, 0);
      // 4: load on the boundary edge itself
      for (int i = 0; i < 16 && !next_is_boundary(); i++) step(1, 0, 0);
      step(1, 1, 16'h5555);
      repeat (10) step(1, 0, 0);
      // 5: drop en mid-frame, then raise it again
      repeat (3) step(1, 0, 0);
      repeat (4) step(0, 0, 0);
      repeat (12) step(1, 0, 0);
      // 6: asynchronous reset while scanning
      repeat (3) step(1, 0, 0);
      mid_reset();
      repeat (10) step(1, 0, 0);
      // random phase
      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_reset();
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, 16'($urandom));
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
